// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses PLL reset, qualifies LOCK, sequences the system
// reset and re-runs the PLL reset whenever lock is lost. Single clkin domain.
module pll_lock_supervisor #(
  parameter int RESET_CYCLES        = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int RELEASE_DELAY       = 64,
  parameter int MAX_RETRIES         = 4
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       lock,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [7:0] relock_cnt
);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int TMO_W = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
  localparam int STB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int REL_W = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
  localparam int RTY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_DELAY - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  localparam logic [RST_W-1:0] RST_ONE = RST_W'(1);
  localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);
  localparam logic [STB_W-1:0] STB_ONE = STB_W'(1);
  localparam logic [REL_W-1:0] REL_ONE = REL_W'(1);
  localparam logic [RTY_W-1:0] RTY_ONE = RTY_W'(1);

  state_t             state_r, state_nxt_s;
  logic [1:0]         lock_sync_r;
  logic               lock_s;
  logic [RST_W-1:0]   rst_cnt_r, rst_cnt_nxt_s;
  logic [TMO_W-1:0]   tmo_cnt_r, tmo_cnt_nxt_s;
  logic [STB_W-1:0]   stb_cnt_r, stb_cnt_nxt_s;
  logic [REL_W-1:0]   rel_cnt_r, rel_cnt_nxt_s;
  logic [RTY_W-1:0]   retry_cnt_r, retry_nxt_s;
  logic [7:0]         relock_nxt_s;
  logic               pll_reset_nxt_s, sys_rst_nxt_s, ready_nxt_s, fail_nxt_s;

  assign lock_s = lock_sync_r[1];

  // Two-flop synchronizer for the asynchronous LOCK input.
  always_ff @(posedge clkin) begin
    if (rst) begin
      lock_sync_r <= 2'b00;
    end else begin
      lock_sync_r <= {lock_sync_r[0], lock};
    end
  end

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_nxt_s   = state_r;
    rst_cnt_nxt_s = {RST_W{1'b0}};
    tmo_cnt_nxt_s = {TMO_W{1'b0}};
    stb_cnt_nxt_s = {STB_W{1'b0}};
    rel_cnt_nxt_s = {REL_W{1'b0}};
    retry_nxt_s   = retry_cnt_r;
    relock_nxt_s  = relock_cnt;

    case (state_r)
      S_RESET: begin
        if (rst_cnt_r == RST_LAST) state_nxt_s = S_WAIT_LOCK;
        else                       rst_cnt_nxt_s = rst_cnt_r + RST_ONE;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt_s = S_STABLE;
        end else if (tmo_cnt_r == TMO_LAST) begin
          retry_nxt_s = retry_cnt_r + RTY_ONE;
          if (retry_nxt_s == RTY_MAX) state_nxt_s = S_FAIL;
          else                        state_nxt_s = S_RESET;
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + TMO_ONE;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_nxt_s = S_WAIT_LOCK;
        end else if (stb_cnt_r == STB_LAST) begin
          state_nxt_s = S_RELEASE;
          retry_nxt_s = {RTY_W{1'b0}};
        end else begin
          stb_cnt_nxt_s = stb_cnt_r + STB_ONE;
        end
      end
      S_RELEASE: begin
        // A loss here re-runs the PLL reset without counting as a relock.
        if (!lock_s)                    state_nxt_s = S_RESET;
        else if (rel_cnt_r == REL_LAST) state_nxt_s = S_RUN;
        else                            rel_cnt_nxt_s = rel_cnt_r + REL_ONE;
      end
      S_RUN: begin
        if (!lock_s) begin
          state_nxt_s = S_RESET;
          if (relock_cnt != 8'hFF) relock_nxt_s = relock_cnt + 8'd1;
          else                     relock_nxt_s = relock_cnt;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_FAIL: begin
        state_nxt_s = S_FAIL;
      end
      default: begin
        state_nxt_s = S_RESET;
      end
    endcase

    // Outputs follow the next state so they change on the transition edge.
    pll_reset_nxt_s = 1'b0;
    sys_rst_nxt_s   = 1'b1;
    ready_nxt_s     = 1'b0;
    fail_nxt_s      = 1'b0;
    case (state_nxt_s)
      S_RESET: begin
        pll_reset_nxt_s = 1'b1;
      end
      S_WAIT_LOCK, S_STABLE, S_RELEASE: begin
        pll_reset_nxt_s = 1'b0;
      end
      S_RUN: begin
        sys_rst_nxt_s = 1'b0;
        ready_nxt_s   = 1'b1;
      end
      S_FAIL: begin
        pll_reset_nxt_s = 1'b1;
        fail_nxt_s      = 1'b1;
      end
      default: begin
        pll_reset_nxt_s = 1'b1;
      end
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_r     <= S_RESET;
      rst_cnt_r   <= {RST_W{1'b0}};
      tmo_cnt_r   <= {TMO_W{1'b0}};
      stb_cnt_r   <= {STB_W{1'b0}};
      rel_cnt_r   <= {REL_W{1'b0}};
      retry_cnt_r <= {RTY_W{1'b0}};
      relock_cnt  <= 8'd0;
      pll_reset   <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      rst_cnt_r   <= rst_cnt_nxt_s;
      tmo_cnt_r   <= tmo_cnt_nxt_s;
      stb_cnt_r   <= stb_cnt_nxt_s;
      rel_cnt_r   <= rel_cnt_nxt_s;
      retry_cnt_r <= retry_nxt_s;
      relock_cnt  <= relock_nxt_s;
      pll_reset   <= pll_reset_nxt_s;
      sys_rst     <= sys_rst_nxt_s;
      ready       <= ready_nxt_s;
      fail        <= fail_nxt_s;
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed timing scenarios plus randomized lock
// traffic, all compared against a phase/elapsed-time reference model.
module tb_pll_lock_supervisor;

  localparam int RC = 4;
  localparam int SC = 8;
  localparam int TC = 32;
  localparam int RD = 4;
  localparam int MR = 2;

  localparam int PH_RESET = 0, PH_WAIT = 1, PH_STABLE = 2, PH_RELEASE = 3, PH_RUN = 4, PH_FAIL = 5;

  logic       clkin;
  logic       rst;
  logic       lock;
  logic       pll_reset, sys_rst, ready, fail;
  logic [7:0] relock_cnt;
  logic [11:0] dut_vec;
  logic [11:0] exp_vec;

  int n_checks = 0;
  int n_fail   = 0;

  int m_phase = PH_RESET;
  int m_cyc = 0;
  int m_enter = 0;
  int m_retry = 0;
  int m_relock = 0;
  bit lq[$];

  pll_lock_supervisor #(
    .RESET_CYCLES(RC), .LOCK_STABLE_CYCLES(SC), .LOCK_TIMEOUT_CYCLES(TC),
    .RELEASE_DELAY(RD), .MAX_RETRIES(MR)
  ) dut (
    .clkin(clkin), .rst(rst), .lock(lock), .pll_reset(pll_reset),
    .sys_rst(sys_rst), .ready(ready), .fail(fail), .relock_cnt(relock_cnt)
  );

  assign dut_vec = {pll_reset, sys_rst, ready, fail, relock_cnt};

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // Reference: lock seen by the FSM is the lock sampled two edges earlier;
  // each phase lasts a fixed number of cycles measured from its entry.
  task automatic model_edge(input bit r, input bit l);
    bit ls;
    int n;
    int nxt;
    if (r) begin
      m_phase = PH_RESET; m_retry = 0; m_relock = 0;
      lq.delete(); lq.push_back(1'b0); lq.push_back(1'b0);
      m_cyc++; m_enter = m_cyc;
    end else begin
      ls = lq.pop_front();
      lq.push_back(l);
      n = m_cyc - m_enter + 1;
      nxt = m_phase;
      case (m_phase)
        PH_RESET:   if (n >= RC) nxt = PH_WAIT;
        PH_WAIT: begin
          if (ls) nxt = PH_STABLE;
          else if (n >= TC) begin
            m_retry++;
            nxt = (m_retry >= MR) ? PH_FAIL : PH_RESET;
          end
        end
        PH_STABLE: begin
          if (!ls) nxt = PH_WAIT;
          else if (n >= SC) begin nxt = PH_RELEASE; m_retry = 0; end
        end
        PH_RELEASE: begin
          if (!ls) nxt = PH_RESET;
          else if (n >= RD) nxt = PH_RUN;
        end
        PH_RUN: begin
          if (!ls) begin nxt = PH_RESET; if (m_relock < 255) m_relock++; end
        end
        default: nxt = m_phase;
      endcase
      m_cyc++;
      if (nxt != m_phase) begin m_phase = nxt; m_enter = m_cyc; end
    end
    exp_vec = {(m_phase == PH_RESET || m_phase == PH_FAIL), (m_phase != PH_RUN),
               (m_phase == PH_RUN), (m_phase == PH_FAIL), 8'(m_relock)};
  endtask

  // One clock: drive at negedge (optional sub-cycle glitch), model at posedge, settle.
  task automatic tick(input bit l, input bit r, input bit g);
    @(negedge clkin);
    lock = l; rst = r;
    if (g) begin #2; lock = ~l; #1; lock = l; end
    @(posedge clkin);
    model_edge(r, l);
    #1;
  endtask

  task automatic apply_reset(input bit l);
    tick(l, 1'b1, 1'b0);
    tick(l, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    lock = 1'b0; rst = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (dut_vec !== 12'hC00) begin
      n_fail++; $display("FAIL reset_state got=%h exp=%h", dut_vec, 12'hC00);
    end
  endtask

  task automatic test_nominal();
    apply_reset(1'b1);
    for (int c = 0; c <= 25; c++) begin
      n_checks++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL nominal_model c=%0d got=%h exp=%h", c, dut_vec, exp_vec); end
      n_checks++;
      if (pll_reset !== (c < 4) || ready !== (c >= 17) || sys_rst !== (c < 17)) begin
        n_fail++; $display("FAIL nominal_timing c=%0d got pll=%b rdy=%b srst=%b", c, pll_reset, ready, sys_rst);
      end
      tick(1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_bounce();
    apply_reset(1'b1);
    for (int c = 0; c <= 35; c++) begin
      n_checks++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL bounce_model c=%0d got=%h exp=%h", c, dut_vec, exp_vec); end
      n_checks++;
      if (pll_reset !== (c < 4) || ready !== (c >= 25)) begin
        n_fail++; $display("FAIL bounce_timing c=%0d got pll=%b rdy=%b exp rdy=%b", c, pll_reset, ready, (c >= 25));
      end
      tick(!(c == 8 || c == 9), 1'b0, 1'b0);
    end
  endtask

  task automatic test_run_loss();
    apply_reset(1'b1);
    for (int c = 0; c <= 45; c++) begin
      n_checks++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL runloss_model c=%0d got=%h exp=%h", c, dut_vec, exp_vec); end
      n_checks++;
      if (pll_reset !== (c < 4 || (c >= 23 && c <= 26)) ||
          ready !== ((c >= 17 && c < 23) || c >= 40) ||
          sys_rst !== !((c >= 17 && c < 23) || c >= 40) ||
          relock_cnt !== ((c >= 23) ? 8'd1 : 8'd0)) begin
        n_fail++; $display("FAIL runloss_timing c=%0d got pll=%b rdy=%b srst=%b relock=%0d", c, pll_reset, ready, sys_rst, relock_cnt);
      end
      tick(c != 20, 1'b0, 1'b0);
    end
  endtask

  task automatic test_glitch();
    apply_reset(1'b1);
    for (int c = 0; c <= 35; c++) begin
      n_checks++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL glitch_model c=%0d got=%h exp=%h", c, dut_vec, exp_vec); end
      n_checks++;
      if (ready !== (c >= 17) || relock_cnt !== 8'd0) begin
        n_fail++; $display("FAIL glitch_ignored c=%0d got rdy=%b relock=%0d exp rdy=%b relock=0", c, ready, relock_cnt, (c >= 17));
      end
      tick(1'b1, 1'b0, (c >= 18 && c < 30));
    end
  endtask

  task automatic test_release_loss();
    apply_reset(1'b1);
    for (int c = 0; c <= 35; c++) begin
      n_checks++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL relloss_model c=%0d got=%h exp=%h", c, dut_vec, exp_vec); end
      n_checks++;
      if (sys_rst !== (c < 32) || ready !== (c >= 32) || relock_cnt !== 8'd0 ||
          pll_reset !== (c < 4 || (c >= 15 && c <= 18))) begin
        n_fail++; $display("FAIL relloss_timing c=%0d got pll=%b srst=%b rdy=%b relock=%0d", c, pll_reset, sys_rst, ready, relock_cnt);
      end
      tick(!(c == 12 || c == 13), 1'b0, 1'b0);
    end
  endtask

  task automatic test_timeout_fail();
    apply_reset(1'b0);
    for (int c = 0; c <= 90; c++) begin
      n_checks++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL timeout_model c=%0d got=%h exp=%h", c, dut_vec, exp_vec); end
      n_checks++;
      if (pll_reset !== (c < 4 || (c >= 36 && c < 40) || c >= 72) || fail !== (c >= 72) ||
          sys_rst !== 1'b1 || ready !== 1'b0) begin
        n_fail++; $display("FAIL timeout_timing c=%0d got pll=%b fail=%b srst=%b rdy=%b", c, pll_reset, fail, sys_rst, ready);
      end
      tick(1'b0, 1'b0, 1'b0);
    end
    tick(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (dut_vec !== 12'hC00) begin n_fail++; $display("FAIL fail_cleared_by_rst got=%h exp=%h", dut_vec, 12'hC00); end
    for (int c = 0; c <= 8; c++) begin
      n_checks++;
      if (pll_reset !== (c < 4) || fail !== 1'b0 || dut_vec !== exp_vec) begin
        n_fail++; $display("FAIL restart_after_fail c=%0d got=%h exp=%h", c, dut_vec, exp_vec);
      end
      tick(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_saturation();
    int k;
    apply_reset(1'b1);
    for (int i = 0; i <= 260; i++) begin
      k = 0;
      while (ready !== 1'b1 && k < 80) begin
        tick(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL sat_model i=%0d got=%h exp=%h", i, dut_vec, exp_vec); end
        k++;
      end
      n_checks++;
      if (ready !== 1'b1 || relock_cnt !== 8'((i > 255) ? 255 : i)) begin
        n_fail++; $display("FAIL sat_count i=%0d got rdy=%b relock=%0d exp rdy=1 relock=%0d", i, ready, relock_cnt, (i > 255) ? 255 : i);
      end
      if (i < 260) begin
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (sys_rst !== 1'b1 || ready !== 1'b0 || dut_vec !== exp_vec) begin
          n_fail++; $display("FAIL sat_loss_latency i=%0d got=%h exp=%h", i, dut_vec, exp_vec);
        end
      end
    end
  endtask

  task automatic test_random();
    int c;
    int seg_len;
    bit v;
    bit r;
    apply_reset(1'b1);
    c = 0;
    while (c < 3000) begin
      v = ($urandom_range(0, 3) != 0);
      if (v) seg_len = $urandom_range(1, 60);
      else if ($urandom_range(0, 9) == 0) seg_len = $urandom_range(60, 120);
      else seg_len = $urandom_range(1, 4);
      for (int j = 0; j < seg_len && c < 3000; j++) begin
        r = ($urandom_range(0, (m_phase == PH_FAIL) ? 40 : 499) == 0);
        tick(v, r, ($urandom_range(0, 7) == 0));
        n_checks++;
        if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL random_model c=%0d got=%h exp=%h", c, dut_vec, exp_vec); end
        n_checks++;
        if ((ready === 1'b1) && (fail !== 1'b0 || sys_rst !== 1'b0 || pll_reset !== 1'b0)) begin
          n_fail++; $display("FAIL random_ready_excl c=%0d got=%h", c, dut_vec);
        end
        c++;
      end
    end
  endtask

  initial begin
    lq.push_back(1'b0);
    lq.push_back(1'b0);
    exp_vec = 12'hC00;
    test_reset();
    test_nominal();
    test_bounce();
    test_run_loss();
    test_glitch();
    test_release_loss();
    test_timeout_fail();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Purpose: drives the PLL RESET input from the consumer side and watches LOCK. It qualifies lock, releases the system reset, and re-runs PLL reset whenever lock is lost. It runs on the free-running 50 MHz PLL input clock.

Interface
REQ-001 Parameters (name, default, meaning):
- RESET_CYCLES, 16: pll_reset pulse width in cycles.
- LOCK_STABLE_CYCLES, 1024: consecutive synced-lock-high cycles required to qualify lock.
- LOCK_TIMEOUT_CYCLES, 100000: maximum wait for lock after a PLL reset (2 ms at 50 MHz).
- RELEASE_DELAY, 64: extra cycles sys_rst stays high after lock qualifies.
- MAX_RETRIES, 4: consecutive timeouts before entering FAIL.

REQ-002 Ports (name, direction, width, meaning):
- clkin, in, 1: sole clock; single clock domain.
- rst, in, 1: synchronous, active-high reset.
- lock, in, 1: PLL LOCK, asynchronous to clkin.
- pll_reset, out, 1: drives PLL RESET, active-high.
- sys_rst, out, 1: synchronous active-high reset for PLL-clocked logic.
- ready, out, 1: lock qualified and system running.
- fail, out, 1: retry budget exhausted.
- relock_cnt, out, 8: count of lock losses while in RUN, saturating.

REQ-003 All outputs SHALL be driven directly from flops; there SHALL be no combinational path from input to output.

Function
REQ-004 lock SHALL pass through a 2-flop synchronizer; the result is lock_s. Only lock_s is used internally.

REQ-005 FSM states SHALL be RESET, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL.

REQ-006 RESET:
- pll_reset=1, sys_rst=1.
- Hold for exactly RESET_CYCLES cycles, then go to WAIT_LOCK.
- Every entry restarts the count.

REQ-007 WAIT_LOCK:
- pll_reset=0; the timeout counter counts from 0.
- lock_s=1: go to STABLE.
- Counter reaches LOCK_TIMEOUT_CYCLES-1 with lock_s=0: increment retry_cnt.
- On timeout, if retry_cnt becomes MAX_RETRIES, go to FAIL; otherwise go to RESET.

REQ-008 STABLE:
- Counts consecutive lock_s=1 cycles.
- lock_s=0 on any cycle: go to WAIT_LOCK, with the timeout counter restarted.
- Count reaches LOCK_STABLE_CYCLES: go to RELEASE and clear retry_cnt.

REQ-009 RELEASE:
- sys_rst stays 1 for RELEASE_DELAY cycles, then go to RUN.
- lock_s=0 during RELEASE: go to RESET; relock_cnt is not incremented.

REQ-010 RUN:
- sys_rst=0, ready=1, pll_reset=0.
- lock_s=0: on that same edge assert sys_rst=1 and ready=0, increment relock_cnt (saturating at 255), go to RESET.

REQ-011 FAIL:
- pll_reset=1, sys_rst=1, fail=1, ready=0.
- FAIL is terminal; it is exited only by rst.

REQ-012 Lock loss to sys_rst latency SHALL be at most 3 clkin edges after lock falls: 2 synchronizer edges plus 1 register edge.

REQ-013 All counters SHALL size to their parameter with $clog2 and SHALL never wrap. Each counter SHALL clear on every state entry.

REQ-014 A lock glitch shorter than 1 cycle that is not captured by the synchronizer SHALL have no effect. A captured glitch SHALL be treated as a real loss.

REQ-015 ready and fail SHALL never both be 1. ready=1 SHALL imply sys_rst=0 and pll_reset=0.

Reset
REQ-016 While rst=1, on each edge:
- State goes to RESET with all counters at 0.
- Synchronizer flops are 0.
- pll_reset=1, sys_rst=1, ready=0, fail=0, relock_cnt=0.

REQ-017 rst asserted in any state, including FAIL and mid-RUN, SHALL take effect on the next edge. After rst deasserts, the RESET-state count starts from 0.

Verification
Bench parameters: RESET_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, RELEASE_DELAY=4, MAX_RETRIES=2.

REQ-018 Nominal start:
- Stimulus: lock held 1 throughout; rst deasserted at cycle 0.
- Response: pll_reset high for cycles 0-3; ready first high at cycle 17; sys_rst falls on the same edge.

REQ-019 Bounce during qualification:
- Stimulus: lock drops for 2 cycles at STABLE count 5.
- Response: return to WAIT_LOCK, then a full 8-cycle requalification; no extra pll_reset pulse.

REQ-020 Loss in RUN:
- Stimulus: lock falls while in RUN.
- Response: sys_rst=1 and ready=0 within 3 edges; relock_cnt goes 0 to 1; a 4-cycle pll_reset pulse follows; ready returns after requalification.

REQ-021 Timeouts to FAIL:
- Stimulus: lock held 0.
- Response: two 4-cycle pll_reset pulses 36 cycles apart (4 reset + 32 timeout); after the second timeout, fail=1 and pll_reset=1 stay steady.
- Then pulse rst: fail=0, and the sequence restarts.

REQ-022 Saturation:
- Stimulus: 260 lock losses in RUN.
- Response: relock_cnt stops at 255.

REQ-023 Loss during RELEASE:
- Stimulus: lock falls during RELEASE.
- Response: return to RESET with relock_cnt unchanged and sys_rst held at 1 throughout.
